// File: rtl/cm_coef_loader_if.sv
// Configuration / commit handshake bundle for the coefficient loader.
// The master side streams coefficient words and requests scenario changes;
// the slave side (the loader) reports readiness, commits and protocol errors.
interface cm_coef_loader_if;
    logic        cfg_start;
    logic        cfg_valid;
    logic [15:0] cfg_data;
    logic        scen_ch;
    logic        coef_rdy;
    logic        commit;
    logic        load_err;

    modport master (
        output cfg_start, cfg_valid, cfg_data, scen_ch,
        input  coef_rdy, commit, load_err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, scen_ch,
        output coef_rdy, commit, load_err
    );
endinterface

// File: rtl/cm_coef_loader.sv
// Double-buffered coefficient loader for a complex-multiply stage.
// Six 16-bit words are streamed into a shadow bank; a scenario change commits
// the full shadow bank to the active registers in one edge and restarts the
// timestamp accumulator. Protocol misuse is flagged with a one-cycle error.
module cm_coef_loader #(
    parameter int TS_W = 32
) (
    input  logic               CLK,
    input  logic               reset,
    cm_coef_loader_if.slave    cfg,
    input  logic [15:0]        ts_inc,
    output logic [15:0]        int1_real,
    output logic [15:0]        int1_img,
    output logic [15:0]        int2_real,
    output logic [15:0]        int2_img,
    output logic [15:0]        int3_real,
    output logic [15:0]        int3_img,
    output logic [TS_W-1:0]    ts_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [2:0]        cnt_r;
    logic [2:0]        cnt_next_s;
    logic              wr_en_s;
    logic [2:0]        wr_idx_s;
    logic              commit_s;
    logic              err_s;

    logic [15:0]       shadow_r [6];
    logic [15:0]       active_r [6];
    logic [TS_W-1:0]   ts_r;
    logic              commit_r;
    logic              load_err_r;
    logic              coef_rdy_r;

    // Next-state decode: word writes, commit requests and protocol errors.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        wr_en_s      = 1'b0;
        wr_idx_s     = cnt_r;
        commit_s     = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            FULL: begin
                if (cfg.scen_ch || cfg.cfg_start) begin
                    // Commit (if requested) happens first; a restart and/or a
                    // same-cycle word then begins the next load at word 0.
                    commit_s = cfg.scen_ch;
                    if (cfg.cfg_valid) begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = 3'd0;
                        cnt_next_s   = 3'd1;
                        state_next_s = LOAD;
                    end else begin
                        cnt_next_s   = 3'd0;
                        state_next_s = IDLE;
                    end
                end else if (cfg.cfg_valid) begin
                    // Bank already full: the extra word is dropped.
                    err_s = 1'b1;
                end else begin
                    state_next_s = FULL;
                end
            end
            IDLE, LOAD: begin
                // A commit request before the bank is full is an error only;
                // the load in progress carries on.
                err_s = cfg.scen_ch;
                if (cfg.cfg_start) begin
                    if (cfg.cfg_valid) begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = 3'd0;
                        cnt_next_s   = 3'd1;
                        state_next_s = LOAD;
                    end else begin
                        cnt_next_s   = 3'd0;
                        state_next_s = IDLE;
                    end
                end else if (cfg.cfg_valid) begin
                    wr_en_s    = 1'b1;
                    wr_idx_s   = cnt_r;
                    cnt_next_s = cnt_r + 3'd1;
                    if (cnt_r == 3'd5) begin
                        state_next_s = FULL;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 3'd0;
            end
        endcase
    end

    // Control state, word counter and the registered status pulses.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 3'd0;
            commit_r   <= 1'b0;
            load_err_r <= 1'b0;
            coef_rdy_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            commit_r   <= commit_s;
            load_err_r <= err_s;
            coef_rdy_r <= (state_next_s == FULL);
        end
    end

    // Shadow bank: written one word at a time by the loader.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                shadow_r[i] <= 16'h0000;
            end
        end else if (wr_en_s) begin
            shadow_r[wr_idx_s] <= cfg.cfg_data;
        end
    end

    // Active bank: copies the whole shadow bank only on a commit edge, so a
    // same-cycle word-0 write lands in the shadow for the next load.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                active_r[i] <= 16'h0000;
            end
        end else if (commit_s) begin
            for (int i = 0; i < 6; i++) begin
                active_r[i] <= shadow_r[i];
            end
        end
    end

    // Timestamp accumulator: free-running wrap-around sum, zeroed on commit.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ts_r <= {TS_W{1'b0}};
        end else if (commit_s) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(ts_inc);
        end
    end

    assign int1_real    = active_r[0];
    assign int1_img     = active_r[1];
    assign int2_real    = active_r[2];
    assign int2_img     = active_r[3];
    assign int3_real    = active_r[4];
    assign int3_img     = active_r[5];
    assign ts_out       = ts_r;
    assign cfg.coef_rdy = coef_rdy_r;
    assign cfg.commit   = commit_r;
    assign cfg.load_err = load_err_r;

endmodule
